// File: rtl/ame_grad_filter.sv
// Sobel/Prewitt gradient engine: streams N+2 columns of N+2 pixels and produces an
// N x N block of wrapped signed column-difference gradients with a one-cycle done pulse.
module ame_grad_filter #(
  parameter int BLK_SIZE       = 4,
  parameter int LINE_DATA_BITS = 8,
  parameter int COMP_DATA_BITS = 11
) (
  input  logic                                               clk_i,
  input  logic                                               rst_n_i,
  input  logic                                               comp_init_i,
  input  logic                                               mode_i,
  input  logic                                               line_valid_i,
  input  logic [BLK_SIZE+1:0][LINE_DATA_BITS-1:0]            line_data_i,
  output logic                                               busy_o,
  output logic                                               comp_done_o,
  output logic [BLK_SIZE-1:0][BLK_SIZE-1:0][COMP_DATA_BITS-1:0] comp_data_o
);
  localparam int N  = BLK_SIZE;
  localparam int CW = $clog2(BLK_SIZE + 2);
  localparam int SW = LINE_DATA_BITS + 2;

  typedef logic [COMP_DATA_BITS-1:0] comp_t;
  typedef comp_t [N-1:0][N-1:0] blk_t;
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOAD = 1'b1} state_t;

  state_t          state_r;
  logic [CW-1:0]   col_r;
  logic            mode_r;
  logic            busy_r;
  logic            done_r;
  blk_t            acc_r;
  blk_t            data_r;

  logic            accept_s;
  logic            last_s;
  comp_t [N-1:0]   sum_s;
  blk_t            acc_nxt_s;

  // Weighted three-tap column sum, computed at full width then wrapped to the result width.
  function automatic comp_t col_sum(input logic [LINE_DATA_BITS-1:0] top,
                                    input logic [LINE_DATA_BITS-1:0] mid,
                                    input logic [LINE_DATA_BITS-1:0] bot,
                                    input logic                      prewitt);
    logic [SW-1:0] mid_w;
    logic [SW-1:0] total;
    if (prewitt) mid_w = {2'b00, mid};
    else         mid_w = {1'b0, mid, 1'b0};
    total = {2'b00, top} + {2'b00, bot} + mid_w;
    return comp_t'(total);
  endfunction

  // Column acceptance and last-column detection.
  always_comb begin
    if (state_r == ST_LOAD) accept_s = line_valid_i;
    else                    accept_s = 1'b0;
    if (col_r == CW'(N + 1)) last_s = accept_s;
    else                     last_s = 1'b0;
  end

  // Per-row kernel sums of the incoming column, using the mode latched at init.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      sum_s[r] = col_sum(line_data_i[r], line_data_i[r+1], line_data_i[r+2], mode_r);
    end
  end

  // Column k seeds acc[.][k] with -s and completes acc[.][k-2] with +s.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (accept_s && (int'(col_r) == c)) begin
          acc_nxt_s[r][c] = {COMP_DATA_BITS{1'b0}} - sum_s[r];
        end else if (accept_s && (int'(col_r) == c + 2)) begin
          acc_nxt_s[r][c] = acc_r[r][c] + sum_s[r];
        end else begin
          acc_nxt_s[r][c] = acc_r[r][c];
        end
      end
    end
  end

  // Control FSM, accumulator array and held output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= ST_IDLE;
      col_r   <= {CW{1'b0}};
      mode_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      acc_r   <= '0;
      data_r  <= '0;
    end else begin
      acc_r  <= acc_nxt_s;
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (comp_init_i) begin
            state_r <= ST_LOAD;
            col_r   <= {CW{1'b0}};
            mode_r  <= mode_i;
            busy_r  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (last_s) begin
            data_r <= acc_nxt_s;
            done_r <= 1'b1;
            col_r  <= {CW{1'b0}};
            // An init on the last column chains straight into the next block.
            if (comp_init_i) begin
              mode_r <= mode_i;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end else if (accept_s) begin
            col_r <= col_r + CW'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_r;
  assign comp_done_o = done_r;
  assign comp_data_o = data_r;

endmodule
